pipe_stage_reg: RTL

- Parametrised successor to the fixed inter-stage pipeline registers (IF/ID … MEM/WB).
- One generic stage register with a valid/ready handshake, synchronous flush (bubble insertion) and an optional 2-entry skid buffer that breaks the combinational ready path.
- Control fields (write enables, mux selects) are split from data fields, so bubbles never carry live enables.
- Instantiated between any two core stages; the ready/valid pair replaces ad-hoc stall wiring.

---
 rtl/pipe_stage_reg_if.sv | 25 ++
 rtl/pipe_stage_reg.sv | 112 +++++++++++
 2 files changed

// File: rtl/pipe_stage_reg_if.sv
// Handshake and payload bundle between two pipeline stages.
// The stage under control takes the slave view; whatever drives it takes the master view.
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 160
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage register: valid/ready handshake, synchronous flush, optional 2-entry skid.
// Control bits are zeroed on flush and gated by valid, so bubbles never carry live enables.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 160,
  parameter int SKID   = 0
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stage_reg_if.slave  bus,
  input  logic             flush,
  output logic [1:0]       occupancy
);

  logic              m_valid_q, m_valid_d;
  logic              s_valid_q, s_valid_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic              in_ready;
  logic              in_xfer;
  logic              out_xfer;

  // SKID=0 passes ready straight through; SKID=1 derives it from the skid slot only.
  generate
    if (SKID == 0) begin : g_comb_ready
      assign in_ready = bus.out_ready | ~m_valid_q;
    end else begin : g_reg_ready
      assign in_ready = ~s_valid_q;
    end
  endgenerate

  assign in_xfer  = bus.in_valid & in_ready;
  assign out_xfer = m_valid_q & bus.out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_ctrl_d  = m_ctrl_q;
    s_ctrl_d  = s_ctrl_q;
    m_data_d  = m_data_q;
    s_data_d  = s_data_q;

    if (flush) begin
      // Data registers deliberately keep their contents; only valid and control are killed.
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      m_ctrl_d  = '0;
      s_ctrl_d  = '0;
    end else if (SKID == 0) begin
      if (in_xfer) begin
        m_valid_d = 1'b1;
        m_ctrl_d  = bus.in_ctrl;
        m_data_d  = bus.in_data;
      end else if (out_xfer) begin
        m_valid_d = 1'b0;
      end
    end else begin
      if (out_xfer) begin
        if (s_valid_q) begin
          // in_ready is low whenever the skid slot is full, so no input can arrive here.
          m_valid_d = 1'b1;
          m_ctrl_d  = s_ctrl_q;
          m_data_d  = s_data_q;
          s_valid_d = 1'b0;
        end else if (in_xfer) begin
          m_valid_d = 1'b1;
          m_ctrl_d  = bus.in_ctrl;
          m_data_d  = bus.in_data;
        end else begin
          m_valid_d = 1'b0;
        end
      end else if (in_xfer) begin
        if (!m_valid_q) begin
          m_valid_d = 1'b1;
          m_ctrl_d  = bus.in_ctrl;
          m_data_d  = bus.in_data;
        end else begin
          s_valid_d = 1'b1;
          s_ctrl_d  = bus.in_ctrl;
          s_data_d  = bus.in_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_ctrl_q  <= '0;
      s_ctrl_q  <= '0;
      m_data_q  <= '0;
      s_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_ctrl_q  <= m_ctrl_d;
      s_ctrl_q  <= s_ctrl_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = m_valid_q;
  assign bus.out_ctrl  = m_ctrl_q & {CTRL_W{m_valid_q}};
  assign bus.out_data  = m_data_q;
  assign occupancy     = {1'b0, m_valid_q} + {1'b0, s_valid_q};

endmodule
